irrig_zone_ctrl: RTL and testbench

//  Parametrised tank-and-irrigation controller: fills the tank, then waters up to N_ZONES zones one
//  at a time for a programmed time, each by spray or drip. Round-robin zone arbitration, fill

---
 rtl/irrig_pkg.sv | 17 +
 rtl/irrig_zone_ctrl_if.sv | 37 +++
 rtl/irrig_debounce.sv | 41 ++++
 rtl/irrig_zone_ctrl.sv | 144 ++++++++++++++
 tb/tb_irrig_zone_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irrig_pkg.sv
// Shared types and constants for the tank-and-irrigation controller.
package irrig_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ENCHENDO = 3'd0,
    CHEIO    = 3'd1,
    REGANDO  = 3'd2,
    LIMPANDO = 3'd3,
    ALARME   = 3'd4
  } irrig_state_t;

  localparam logic MODO_SPRAY = 1'b1;
  localparam logic MODO_DRIP  = 1'b0;

endpackage

// File: rtl/irrig_zone_ctrl_if.sv
// Sensor/button inputs and valve/LED outputs of the irrigation controller.
// Optional Ciclos counter output exists only when IRRIG_CYCLE_CNT_EN is defined.
interface irrig_zone_ctrl_if #(
  parameter int N_ZONES = 4,
  parameter int TIME_W  = 8
);
  localparam int ZW = $clog2(N_ZONES);

  logic                L, H, Ve, Al, Ack;
  logic [N_ZONES-1:0]  Req, Modo;
  logic [TIME_W-1:0]   water_time;
  logic                Enchendo, Cheio, Limpando, Alarme, Falha;
  logic                Aspersao, Gotejamento;
  logic [N_ZONES-1:0]  Valvula;
  logic [ZW-1:0]       Zona;
`ifdef IRRIG_CYCLE_CNT_EN
  logic [15:0]         Ciclos;
`endif

  modport master (
    output L, H, Ve, Al, Ack, Req, Modo, water_time,
    input  Enchendo, Cheio, Limpando, Alarme, Falha, Aspersao, Gotejamento,
    input  Valvula, Zona
`ifdef IRRIG_CYCLE_CNT_EN
    , input Ciclos
`endif
  );

  modport slave (
    input  L, H, Ve, Al, Ack, Req, Modo, water_time,
    output Enchendo, Cheio, Limpando, Alarme, Falha, Aspersao, Gotejamento,
    output Valvula, Zona
`ifdef IRRIG_CYCLE_CNT_EN
    , output Ciclos
`endif
  );
endinterface

// File: rtl/irrig_debounce.sv
// Two-flop synchroniser followed by a debounce: the output follows the
// synchronised input only after DB consecutive samples that differ from it.
module irrig_debounce #(
  parameter int DB = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DB + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronise the raw asynchronous input into the Clk domain.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Count disagreeing samples; toggle once DB of them arrive in a row.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (s2 == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(DB - 1)) begin
      cnt  <= '0;
      dout <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/irrig_zone_ctrl.sv
// Tank fill / zone irrigation controller with round-robin zone service,
// fill-timeout fault and debounced alarm.
// Optional feature macro: IRRIG_CYCLE_CNT_EN adds the Ciclos completed-grant counter.
//
//   state    | meaning
//   ENCHENDO | filling tank, fill timer running
//   CHEIO    | tank full, idle, picks next pending zone
//   REGANDO  | watering granted zone, zone timer counting down
//   LIMPANDO | low level seen, waiting for drain valve closed
//   ALARME   | alarm or fill fault, waits for clear (and Ack if faulted)
module irrig_zone_ctrl
  import irrig_pkg::*;
#(
  parameter int N_ZONES      = 4,
  parameter int TIME_W       = 8,
  parameter int FILL_TIMEOUT = 200,
  parameter int ALARM_DB     = 3
) (
  input  logic            Clk,
  input  logic            Rst,
  irrig_zone_ctrl_if.slave bus
);
  localparam int ZW = $clog2(N_ZONES);

  irrig_state_t        state;
  logic [15:0]         fill_cnt;
  logic [TIME_W-1:0]   timer;
  logic [ZW-1:0]       zona, last, pick;
  logic                modo_l, falha, al_db, found;
  logic [N_ZONES-1:0]  pending, zone_oh;
  logic [TIME_W-1:0]   wt_load;
  logic                grant_end, grant_done;

  irrig_debounce #(.DB(ALARM_DB)) u_al_db (
    .Clk  (Clk),
    .Rst  (Rst),
    .din  (bus.Al),
    .dout (al_db)
  );

  assign zone_oh    = N_ZONES'(1) << zona;
  assign wt_load    = (bus.water_time == '0) ? TIME_W'(1) : bus.water_time;
  assign grant_done = (state == REGANDO) && !al_db && !bus.L && (timer == TIME_W'(1));
  assign grant_end  = (state == REGANDO) && !al_db && (bus.L || (timer == TIME_W'(1)));

  // Round-robin: first pending zone after the last one granted, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_ZONES; k++) begin
      if (!found && pending[ZW'((int'(last) + k) % N_ZONES)]) begin
        pick  = ZW'((int'(last) + k) % N_ZONES);
        found = 1'b1;
      end
    end
  end

  // Pending requests: a new request wins over the clear of an ending grant.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) pending <= '0;
    else     pending <= (pending & ~(grant_end ? zone_oh : '0)) | bus.Req;
  end

  // Main sequencing FSM with fill timer and zone timer.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ENCHENDO;
      fill_cnt <= '0;
      timer    <= '0;
      zona     <= '0;
      last     <= ZW'(N_ZONES - 1);
      modo_l   <= 1'b0;
      falha    <= 1'b0;
    end else begin
      case (state)
        ENCHENDO: begin
          if (al_db)      state <= ALARME;
          else if (bus.H) state <= CHEIO;
          else if (fill_cnt == 16'(FILL_TIMEOUT - 1)) begin
            state    <= ALARME;
            falha    <= 1'b1;
            fill_cnt <= fill_cnt + 1'b1;
          end else fill_cnt <= fill_cnt + 1'b1;
        end
        CHEIO: begin
          if (al_db)      state <= ALARME;
          else if (bus.L) state <= LIMPANDO;
          else if (found) begin
            state  <= REGANDO;
            zona   <= pick;
            last   <= pick;
            modo_l <= bus.Modo[pick];
            timer  <= wt_load;
          end
        end
        REGANDO: begin
          if (al_db)                        state <= ALARME;
          else if (bus.L)                   state <= LIMPANDO;
          else if (timer == TIME_W'(1))     state <= CHEIO;
          else                              timer <= timer - 1'b1;
        end
        LIMPANDO: begin
          if (bus.Ve) begin
            state    <= ENCHENDO;
            fill_cnt <= '0;
          end
        end
        ALARME: begin
          if (bus.Ack) falha <= 1'b0;
          if (!al_db && (!falha || bus.Ack)) begin
            state    <= ENCHENDO;
            fill_cnt <= '0;
          end
        end
        default: begin
          state    <= ENCHENDO;
          fill_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.Enchendo    = (state == ENCHENDO);
  assign bus.Cheio       = (state == CHEIO);
  assign bus.Limpando    = (state == LIMPANDO);
  assign bus.Alarme      = (state == ALARME);
  assign bus.Falha       = falha;
  assign bus.Aspersao    = (state == REGANDO) && (modo_l == MODO_SPRAY);
  assign bus.Gotejamento = (state == REGANDO) && (modo_l != MODO_SPRAY);
  assign bus.Valvula     = (state == REGANDO) ? zone_oh : '0;
  assign bus.Zona        = zona;

`ifdef IRRIG_CYCLE_CNT_EN
  logic [15:0] ciclos;

  // Count grants that ran to timer expiry, saturating.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                   ciclos <= '0;
    else if (grant_done && ciclos != 16'hFFFF) ciclos <= ciclos + 1'b1;
  end

  assign bus.Ciclos = ciclos;
`endif
endmodule

// File: tb/tb_irrig_zone_ctrl.sv
// Self-checking bench for irrig_zone_ctrl; expected grants are queued when
// requests are driven and compared when the valves open and close.
module tb_irrig_zone_ctrl;
  localparam int NZ = 4;
  localparam int TW = 8;
  localparam int FT = 200;
  localparam int DB = 3;
  localparam int ZW = 2;
  localparam int PW = NZ + ZW + 2 + 8;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  irrig_zone_ctrl_if #(.N_ZONES(NZ), .TIME_W(TW)) bus ();

  irrig_zone_ctrl #(
    .N_ZONES(NZ), .TIME_W(TW), .FILL_TIMEOUT(FT), .ALARM_DB(DB)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    int   zone;
    logic modo;
    int   len;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected observation word: {valves, zone, spray, drip, open cycles}
  function automatic logic [PW-1:0] exp_word(exp_t e);
    logic [NZ-1:0] oh;
    oh = NZ'(1) << e.zone;
    return {oh, ZW'(e.zone), e.modo, ~e.modo, 8'(e.len)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int zone, input logic modo, input int len);
    exp_t e;
    e.zone = zone; e.modo = modo; e.len = len;
    sbq.push_back(e);
  endtask

  // Wait for a valve to open, then measure the grant until it closes.
  task automatic serve(input int budget, output int gap, output logic [PW-1:0] obs);
    logic [NZ-1:0] v;
    int len;
    gap = 0; len = 0; obs = '0;
    while (gap < budget && bus.Valvula == '0) begin
      tick();
      gap++;
    end
    if (bus.Valvula != '0) begin
      v   = bus.Valvula;
      obs = {bus.Valvula, bus.Zona, bus.Aspersao, bus.Gotejamento, 8'd0};
      while (len < 255 && bus.Valvula == v) begin
        len++;
        tick();
      end
      obs[7:0] = 8'(len);
    end
  endtask

  task automatic wait_valve_on(input int budget);
    int n = 0;
    while (n < budget && bus.Valvula == '0) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.L = 0; bus.H = 0; bus.Ve = 0; bus.Al = 0; bus.Ack = 0;
    bus.Req = '0; bus.Modo = '0; bus.water_time = '0;
    tick(); tick();
    vectors++;
    if ({bus.Enchendo, bus.Cheio, bus.Limpando, bus.Alarme, bus.Falha, bus.Aspersao,
         bus.Gotejamento} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 1000000", {bus.Enchendo, bus.Cheio,
               bus.Limpando, bus.Alarme, bus.Falha, bus.Aspersao, bus.Gotejamento});
    end
    vectors++;
    if ({bus.Valvula, bus.Zona} !== '0) begin
      miscompares++;
      $display("FAIL reset_valve_zona: got %h expected 0", {bus.Valvula, bus.Zona});
    end
    Rst = 1'b0;
    bus.H = 1'b1;
    tick();
    vectors++;
    if ({bus.Enchendo, bus.Cheio} !== 2'b01) begin
      miscompares++;
      $display("FAIL fill_to_full: got %b expected 01", {bus.Enchendo, bus.Cheio});
    end
  endtask

  task automatic test_round_robin();
    int gap;
    logic [PW-1:0] obs;
    exp_t e;
    bus.water_time = 8'd3; bus.Modo = 4'b0000; bus.Req = 4'b0101;
    push(0, 1'b0, 3); push(2, 1'b0, 3);
    tick();
    bus.Req = '0;
    for (int i = 0; i < 2; i++) begin
      serve(20, gap, obs);
      e = sbq.pop_front();
      vectors++;
      if (obs !== exp_word(e)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %h expected %h", i, obs, exp_word(e));
      end
      vectors++;
      if (gap !== 1) begin
        miscompares++;
        $display("FAIL rr_gap%0d: got %0d idle cycles expected 1", i, gap);
      end
    end
  endtask

  task automatic test_spray_zero_time();
    int gap;
    logic [PW-1:0] obs;
    exp_t e;
    bus.Modo = 4'b0010; bus.water_time = '0; bus.Req = 4'b0010;
    push(1, 1'b1, 1);
    tick();
    bus.Req = '0;
    serve(20, gap, obs);
    e = sbq.pop_front();
    vectors++;
    if (obs !== exp_word(e)) begin
      miscompares++;
      $display("FAIL spray_one_cycle: got %h expected %h", obs, exp_word(e));
    end
    vectors++;
    if (bus.Zona !== 2'd1) begin
      miscompares++;
      $display("FAIL zona_hold: got %0d expected 1", bus.Zona);
    end
  endtask

  task automatic test_alarm();
    int gap, n;
    logic seen;
    logic [PW-1:0] obs;
    exp_t e;
    bus.Al = 1'b1; tick(); tick(); bus.Al = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.Alarme) seen = 1'b1;
    end
    vectors++;
    if ({seen, bus.Cheio} !== 2'b01) begin
      miscompares++;
      $display("FAIL glitch_filtered: got %b expected 01", {seen, bus.Cheio});
    end
    bus.water_time = 8'd20; bus.Modo = '0; bus.Req = 4'b1000;
    tick();
    bus.Req = '0;
    wait_valve_on(10);
    vectors++;
    if (bus.Valvula !== 4'b1000) begin
      miscompares++;
      $display("FAIL alarm_grant_open: got %b expected 1000", bus.Valvula);
    end
    tick(); tick();
    bus.Al = 1'b1;
    n = 0;
    while (bus.Valvula != '0 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (!(n <= 2 + DB + 2 && bus.Alarme === 1'b1 && bus.Valvula === '0)) begin
      miscompares++;
      $display("FAIL alarm_close: got %0d cycles alarme=%b, required <= %0d alarme=1",
               n, bus.Alarme, 2 + DB + 2);
    end
    push(3, 1'b0, 20);
    bus.Al = 1'b0;
    serve(40, gap, obs);
    e = sbq.pop_front();
    vectors++;
    if (obs !== exp_word(e)) begin
      miscompares++;
      $display("FAIL alarm_recover_serve: got %h expected %h", obs, exp_word(e));
    end
  endtask

  task automatic test_clean();
    int gap;
    logic [PW-1:0] obs;
    exp_t e;
    bus.water_time = 8'd10; bus.Modo = '0; bus.Req = 4'b0001;
    tick();
    bus.Req = '0;
    wait_valve_on(10);
    tick(); tick(); tick();
    bus.L = 1'b1; bus.Req = 4'b0001;
    tick();
    bus.L = 1'b0; bus.Req = '0;
    vectors++;
    if ({bus.Limpando, bus.Valvula} !== 5'b10000) begin
      miscompares++;
      $display("FAIL clean_entry: got %b expected 10000", {bus.Limpando, bus.Valvula});
    end
    tick(); tick();
    vectors++;
    if (bus.Limpando !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_wait_ve: got %b expected 1", bus.Limpando);
    end
    bus.Ve = 1'b1;
    tick();
    bus.Ve = 1'b0;
    vectors++;
    if (bus.Enchendo !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_to_fill: got %b expected 1", bus.Enchendo);
    end
    push(0, 1'b0, 10);
    serve(20, gap, obs);
    e = sbq.pop_front();
    vectors++;
    if (obs !== exp_word(e)) begin
      miscompares++;
      $display("FAIL req_on_clear_served: got %h expected %h", obs, exp_word(e));
    end
  endtask

  task automatic test_fill_timeout();
    bus.water_time = 8'd10; bus.Req = 4'b0010;
    tick();
    bus.Req = '0;
    wait_valve_on(10);
    #2 Rst = 1'b1;
    #1;
    vectors++;
    if ({bus.Valvula, bus.Enchendo} !== 5'b00001) begin
      miscompares++;
      $display("FAIL async_reset_close: got %b expected 00001", {bus.Valvula, bus.Enchendo});
    end
    bus.H = 1'b0;
    tick();
    Rst = 1'b0;
    repeat (FT - 1) tick();
    vectors++;
    if ({bus.Enchendo, bus.Alarme} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_early: got %b expected 10", {bus.Enchendo, bus.Alarme});
    end
    tick();
    vectors++;
    if ({bus.Alarme, bus.Falha} !== 2'b11) begin
      miscompares++;
      $display("FAIL timeout_fault: got %b expected 11", {bus.Alarme, bus.Falha});
    end
    repeat (5) tick();
    vectors++;
    if ({bus.Alarme, bus.Falha} !== 2'b11) begin
      miscompares++;
      $display("FAIL fault_needs_ack: got %b expected 11", {bus.Alarme, bus.Falha});
    end
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    vectors++;
    if ({bus.Enchendo, bus.Alarme, bus.Falha} !== 3'b100) begin
      miscompares++;
      $display("FAIL ack_release: got %b expected 100", {bus.Enchendo, bus.Alarme, bus.Falha});
    end
  endtask

`ifdef IRRIG_CYCLE_CNT_EN
  task automatic test_cycle_cnt();
    int gap;
    logic [PW-1:0] obs;
    exp_t e;
    Rst = 1'b1; bus.H = 1'b0;
    tick();
    vectors++;
    if (bus.Ciclos !== 16'd0) begin
      miscompares++;
      $display("FAIL ciclos_reset: got %0d expected 0", bus.Ciclos);
    end
    Rst = 1'b0; bus.H = 1'b1;
    tick();
    bus.water_time = 8'd2; bus.Modo = '0; bus.Req = 4'b1111;
    push(0, 1'b0, 2); push(1, 1'b0, 2); push(2, 1'b0, 2);
    tick();
    bus.Req = '0;
    for (int i = 0; i < 3; i++) begin
      serve(20, gap, obs);
      e = sbq.pop_front();
      vectors++;
      if (obs !== exp_word(e)) begin
        miscompares++;
        $display("FAIL cnt_grant%0d: got %h expected %h", i, obs, exp_word(e));
      end
    end
    wait_valve_on(10);
    bus.L = 1'b1;
    tick();
    bus.L = 1'b0;
    vectors++;
    if ({bus.Limpando, bus.Ciclos} !== {1'b1, 16'd3}) begin
      miscompares++;
      $display("FAIL ciclos_count: got limpando=%b ciclos=%0d expected 1 and 3",
               bus.Limpando, bus.Ciclos);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_spray_zero_time();
    test_alarm();
    test_clean();
    test_fill_timeout();
`ifdef IRRIG_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
